// File: rtl/sm_ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin with a bounded hold count; read data is tagged back to the winner one cycle later.
module sm_ram_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

  localparam logic [2:0] HOLD_MAX = 3'(MAX_HOLD);

  owner_e     owner_q, owner_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic       rsp_pending_q, rsp_pending_d;
  logic       rsp_id_q, rsp_id_d;
  logic       win_m1;
  logic       any_gnt;
  logic       win_we;

  always_comb begin
    win_m1 = m1_req;
    if (m0_req && m1_req) begin
      win_m1 = (hold_cnt_q < HOLD_MAX) ? (owner_q == OWN_M1) : (owner_q == OWN_M0);
    end
    // Gating with rst_n keeps the RAM write-free while reset is held.
    any_gnt = (m0_req | m1_req) & rst_n;
    m0_gnt  = any_gnt & ~win_m1;
    m1_gnt  = any_gnt & win_m1;

    win_we    = win_m1 ? m1_we : m0_we;
    ram_addr  = win_m1 ? m1_addr : m0_addr;
    ram_wdata = win_m1 ? m1_wdata : m0_wdata;
    ram_we    = any_gnt & win_we;

    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (any_gnt) begin
      if (win_m1 == (owner_q == OWN_M1)) begin
        if (hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + 3'd1;
      end else begin
        owner_d    = win_m1 ? OWN_M1 : OWN_M0;
        hold_cnt_d = 3'd1;
      end
    end

    rsp_pending_d = any_gnt & ~win_we;
    rsp_id_d      = rsp_pending_d ? win_m1 : rsp_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= OWN_M1;
      hold_cnt_q    <= HOLD_MAX;
      rsp_pending_q <= 1'b0;
      rsp_id_q      <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      hold_cnt_q    <= hold_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  assign m0_rvalid = rsp_pending_q & ~rsp_id_q;
  assign m1_rvalid = rsp_pending_q & rsp_id_q;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_sm_ram_arbiter.sv
// Bench for sm_ram_arbiter: directed scenarios plus randomized traffic against a
// grant-history / memory-array reference model. A second instance runs with MAX_HOLD=1.
module tb_sm_ram_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [5:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_ram_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_wdata, b_ram_rdata;
  logic [5:0]  b_ram_addr;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int          hist[$];
  int          cur_win;
  logic        exp_g0, exp_g1, exp_rv0, exp_rv1, nxt_rv0, nxt_rv1;
  logic [31:0] exp_rdata, nxt_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sm_ram_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  sm_ram_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_rdata(b_ram_rdata)
  );

  // Synchronous RAM: write and registered read on the same edge (read returns old data).
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata   <= mem[ram_addr];
    b_ram_rdata <= mem[b_ram_addr];
  end

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < MH; i++) hist.push_back(1);
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; cur_win = -1;
  endtask

  task automatic apply(input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    int last;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    last = hist[hist.size()-1];
    if (!rst_n)             cur_win = -1;
    else if (r0 && r1)      cur_win = (run_len() < MH) ? last : 1 - last;
    else if (r0)            cur_win = 0;
    else if (r1)            cur_win = 1;
    else                    cur_win = -1;
    exp_g0 = (cur_win == 0);
    exp_g1 = (cur_win == 1);
    #1;
  endtask

  task automatic advance();
    logic w;
    logic [5:0] a;
    logic [31:0] d;
    nxt_rv0 = 1'b0; nxt_rv1 = 1'b0;
    if (cur_win >= 0) begin
      hist.push_back(cur_win);
      if (hist.size() > 32) void'(hist.pop_front());
      w = (cur_win == 0) ? m0_we : m1_we;
      a = (cur_win == 0) ? m0_addr : m1_addr;
      d = (cur_win == 0) ? m0_wdata : m1_wdata;
      $display("txn m%0d %s addr=%0d data=%08h", cur_win, w ? "WR" : "RD", a, w ? d : ref_mem[a]);
      if (w) ref_mem[a] = d;
      else begin
        nxt_rdata = ref_mem[a];
        nxt_rv0 = (cur_win == 0);
        nxt_rv1 = (cur_win == 1);
      end
    end
    @(posedge clk); #1;
    exp_rv0 = nxt_rv0; exp_rv1 = nxt_rv1; exp_rdata = nxt_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd1; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd2; m1_wdata = 32'h2;
    @(posedge clk); #2;
    n_cmp++; if (m0_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt0 got=%b exp=0", m0_gnt); end
    n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt1 got=%b exp=0", m1_gnt); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_read();
    apply(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_err++; $display("FAIL read_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
    n_cmp++; if (ram_addr !== 6'd5) begin n_err++; $display("FAIL read_addr got=%0d exp=5", ram_addr); end
    advance();
    apply(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    n_cmp++; if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1) begin
      n_err++; $display("FAIL read_rvalid got=%b%b exp=%b%b", m0_rvalid, m1_rvalid, exp_rv0, exp_rv1); end
    n_cmp++; if (m0_rdata !== 32'h1234) begin n_err++; $display("FAIL read_rdata got=%h exp=00001234", m0_rdata); end
    advance();
  endtask

  task automatic test_raw();
    apply(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 6'd3, 32'hCAFE);
    n_cmp++; if (m1_gnt !== 1'b1 || ram_we !== 1'b1) begin
      n_err++; $display("FAIL raw_write got gnt1=%b we=%b exp=1 1", m1_gnt, ram_we); end
    advance();
    apply(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    n_cmp++; if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL raw_read_gnt got gnt0=%b rv1=%b exp=1 0", m0_gnt, m1_rvalid); end
    advance();
    apply(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    n_cmp++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp_rdata) begin
      n_err++; $display("FAIL raw_rdata got rv=%b data=%h exp=1 %h", m0_rvalid, m0_rdata, exp_rdata); end
    advance();
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b0, 6'd7, 32'h0, 1'b1, 1'b0, 6'd9, 32'h0);
      n_cmp++; if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
        n_err++; $display("FAIL cont_gnt cyc=%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, exp_g0, exp_g1); end
      n_cmp++; if (m0_gnt !== ((i / MH) % 2 == 0)) begin
        n_err++; $display("FAIL cont_pattern cyc=%0d got gnt0=%b", i, m0_gnt); end
      if (i > 0) begin
        n_cmp++; if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 || (m0_rvalid ^ m1_rvalid) !== 1'b1) begin
          n_err++; $display("FAIL cont_rvalid cyc=%0d got=%b%b exp=%b%b", i, m0_rvalid, m1_rvalid, exp_rv0, exp_rv1); end
        n_cmp++; if (ram_rdata !== exp_rdata) begin
          n_err++; $display("FAIL cont_rdata cyc=%0d got=%h exp=%h", i, ram_rdata, exp_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_hold1();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 6'd7, 32'h0, 1'b1, 1'b0, 6'd9, 32'h0);
      n_cmp++; if (b_m0_gnt !== (i % 2 == 0) || b_m1_gnt !== (i % 2 == 1)) begin
        n_err++; $display("FAIL hold1_gnt cyc=%0d got=%b%b exp=%b%b", i, b_m0_gnt, b_m1_gnt, i % 2 == 0, i % 2 == 1); end
      if (i > 0) begin
        n_cmp++; if (b_m0_rvalid !== ((i - 1) % 2 == 0) || b_m1_rvalid !== ((i - 1) % 2 == 1)) begin
          n_err++; $display("FAIL hold1_rvalid cyc=%0d got=%b%b", i, b_m0_rvalid, b_m1_rvalid); end
      end
      advance();
    end
  endtask

  task automatic test_m1_alone();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(i >= 10, 1'b0, 6'd4, 32'h0, 1'b1, 1'b0, 6'd8, 32'h0);
      n_cmp++; if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
        n_err++; $display("FAIL alone_gnt cyc=%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, exp_g0, exp_g1); end
      if (i == 10) begin
        n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL alone_join got gnt0=%b exp=1", m0_gnt); end
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    advance();
    rst_n = 1'b0;
    m0_we = 1'b1;
    #1;
    n_cmp++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL midrst_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
    n_cmp++; if (ram_we !== 1'b0 || m0_gnt !== 1'b0) begin
      n_err++; $display("FAIL midrst_we got we=%b gnt0=%b exp=0 0", ram_we, m0_gnt); end
    @(posedge clk); #1;
    n_cmp++; if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_rvalid2 got=%b exp=0", m0_rvalid); end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 6'd2, 32'h0, 1'b1, 1'b0, 6'd6, 32'h0);
      n_cmp++; if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
        n_err++; $display("FAIL midrst_gnt cyc=%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, exp_g0, exp_g1); end
      advance();
    end
  endtask

  task automatic test_random();
    logic r0, w0, r1, w1, g0p, g1p;
    logic [5:0] a0, a1;
    logic [31:0] d0, d1;
    r0 = 1'b0; r1 = 1'b0; g0p = 1'b0; g1p = 1'b0;
    w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 300; c++) begin
      if (!(r0 && !g0p)) begin
        r0 = ($urandom % 4) != 0; w0 = 1'($urandom % 2); a0 = 6'($urandom % 16); d0 = $urandom;
      end
      if (!(r1 && !g1p)) begin
        r1 = ($urandom % 4) != 0; w1 = 1'($urandom % 2); a1 = 6'($urandom % 16); d1 = $urandom;
      end
      apply(r0, w0, a0, d0, r1, w1, a1, d1);
      n_cmp++; if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
        n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", c, m0_gnt, m1_gnt, exp_g0, exp_g1); end
      n_cmp++; if (ram_we !== ((cur_win == 0) ? w0 : (cur_win == 1) ? w1 : 1'b0)) begin
        n_err++; $display("FAIL rnd_we cyc=%0d got=%b", c, ram_we); end
      n_cmp++; if (ram_addr !== ((cur_win == 1) ? a1 : a0)) begin
        n_err++; $display("FAIL rnd_addr cyc=%0d got=%0d", c, ram_addr); end
      n_cmp++; if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1) begin
        n_err++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", c, m0_rvalid, m1_rvalid, exp_rv0, exp_rv1); end
      if (exp_rv0 || exp_rv1) begin
        n_cmp++; if ((exp_rv0 ? m0_rdata : m1_rdata) !== exp_rdata) begin
          n_err++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, exp_rv0 ? m0_rdata : m1_rdata, exp_rdata); end
      end
      g0p = exp_g0; g1p = exp_g1;
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h1234; ref_mem[5] = 32'h1234;
    model_reset();
    test_reset();
    test_read();
    test_raw();
    test_contention();
    test_hold1();
    test_m1_alone();
    test_mid_reset();
    test_random();
    apply(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_ram_arbiter.md
Name: sm_ram_arbiter

Overview:
- Shares the single data RAM port between two requesters: m0 (CPU load/store path) and m1 (debug/loader port).
- Sits between the requesters and the RAM. The RAM has 1-cycle synchronous read latency.
- Arbitration is round-robin with a bounded hold count. Read data returns one cycle after acceptance, tagged to the winning requester.

Parameters:
- ADDR_W, 6, RAM word address width.
- DATA_W, 32, data width.
- MAX_HOLD, 4, max consecutive grants to one requester while the other is also requesting (range 1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  m0 transaction request
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  ADDR_W  m0 word address
- m0_wdata  in  DATA_W  m0 write data
- m0_gnt  out  1  m0 request accepted this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  DATA_W  m0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data (valid the cycle after the address)

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - Outputs: m*_gnt=0, m*_rvalid=0, ram_we=0.
  - Registers: owner=1, hold_cnt=MAX_HOLD, rsp_pending=0, rsp_id=0.
- Handshake: a requester holds req/we/addr/wdata stable until gnt. A transaction is accepted in any cycle where req & gnt. gnt is combinational from req and the registered owner/hold_cnt. At most one gnt per cycle.
- Grant selection:
  - Neither requesting: no gnt; ram_we=0; ram_addr/ram_wdata = m0 fields.
  - One requesting: that requester is granted.
  - Both requesting: grant owner if hold_cnt < MAX_HOLD, else the other requester.
- Counter update on each accepted transaction by requester X:
  - X == owner: hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - X != owner: owner=X, hold_cnt=1.
  - Idle cycles leave owner and hold_cnt unchanged.
- RAM drive: ram_addr/ram_wdata/ram_we = winner's fields, combinational. ram_we = winner_we & winner_gnt.
- Read response:
  - An accepted read sets rsp_pending=1 and rsp_id=winner at the next edge. Otherwise rsp_pending=0.
  - m{rsp_id}_rvalid = rsp_pending.
  - rdata of both requesters = ram_rdata, combinational pass-through. Only the rvalid one is meaningful.
  - Latency: accept at cycle N -> rvalid at cycle N+1.
  - Back-to-back reads every cycle are supported: full throughput, one response per cycle.
- Writes: take effect at the acceptance edge; no response.
- Read-after-write to the same address on consecutive cycles returns the new data. This relies on the RAM's write-then-read across edges.
- Simultaneous same-cycle requests to the same address: only the winner is accepted; the loser retries next cycle.
- Reset mid-operation: a pending read response is dropped (rvalid stays 0). No RAM write is issued while rst_n=0.
- MAX_HOLD=1 degenerates to strict alternation under contention.

Test Plan:
- Reset then m0 read addr 5 (RAM[5]=0x1234) -> m0_gnt=1 same cycle; m0_rvalid=1, m0_rdata=0x1234 next cycle; m1_rvalid=0.
- m1 writes 0xCAFE to addr 3, then m0 reads addr 3 the next cycle -> m0_rdata=0xCAFE.
- Both requesters issue continuous reads, MAX_HOLD=4, starting from reset -> grants in order m0×4, m1×4, m0×4…; exactly one rvalid per cycle with the correct rsp_id.
- MAX_HOLD=1, both requesting continuously -> grants strictly alternate m0,m1,m0,m1.
- m1 alone for 10 cycles, then m0 joins -> m1 keeps the grant until hold_cnt reaches 4 (already saturated, so m0 wins on the first contended cycle), then round-robin.
- Assert rst_n=0 for one cycle right after an accepted read -> no rvalid asserted; owner=1, hold_cnt=MAX_HOLD after reset.
